// File: rtl/mlp_dense_engine.sv
// Sequential MLP dense layer: one time-multiplexed signed MAC walks N_OUT neurons x N_IN inputs,
// then requantises (>>> SHIFT), optionally applies ReLU and saturates each result to DATA_W bits.
module mlp_dense_engine #(
    parameter int DATA_W = 8,
    parameter int N_IN   = 4,
    parameter int N_OUT  = 4,
    parameter int SHIFT  = 0,
    localparam int ACC_W = 2*DATA_W + $clog2(N_IN) + 1,
    localparam int WA_W  = (N_IN*N_OUT > 1) ? $clog2(N_IN*N_OUT) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    init,
    output logic                    ready,
    output logic                    valid,
    input  logic                    relu_en,
    input  logic [N_IN*DATA_W-1:0]  input_block,
    output logic [N_OUT*DATA_W-1:0] output_block,
    input  logic                    w_we,
    input  logic [WA_W-1:0]         w_addr,
    input  logic [DATA_W-1:0]       w_data
);
    localparam int N_W = N_IN*N_OUT;
    localparam int IW  = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int JW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2**(DATA_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_STORE} state_t;
    state_t state, state_nxt;

    logic [IW-1:0]            i_cnt;
    logic [JW-1:0]            j_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic                     relu_q;
    logic signed [DATA_W-1:0] x_q     [N_IN];
    logic signed [DATA_W-1:0] w_mem   [N_W];
    logic signed [DATA_W-1:0] res_mem [N_OUT];

    logic                     i_last, j_last, w_wr_ok;
    logic [WA_W:0]            w_addr_ext;
    logic [WA_W-1:0]          w_idx;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_shr;
    logic signed [DATA_W-1:0] res_sat;

    always_comb begin
        ready      = (state == S_IDLE);
        i_last     = (i_cnt == IW'(N_IN-1));
        j_last     = (j_cnt == JW'(N_OUT-1));
        w_addr_ext = {1'b0, w_addr};
        w_wr_ok    = w_we && ready && !init && (w_addr_ext < (WA_W+1)'(N_W));
        w_idx      = WA_W'(int'(j_cnt) * N_IN + int'(i_cnt));
        prod       = (2*DATA_W)'(x_q[i_cnt]) * (2*DATA_W)'(w_mem[w_idx]);
        acc_shr    = acc >>> SHIFT;
        // ReLU takes precedence; saturation bounds are sign-extended to the accumulator width.
        res_sat    = acc_shr[DATA_W-1:0];
        if (relu_q && acc_shr[ACC_W-1])
            res_sat = '0;
        else if (acc_shr > SAT_MAX)
            res_sat = SAT_MAX[DATA_W-1:0];
        else if (acc_shr < SAT_MIN)
            res_sat = SAT_MIN[DATA_W-1:0];
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (init) state_nxt = S_MAC;
            S_MAC:   if (i_last) state_nxt = S_STORE;
            S_STORE: state_nxt = j_last ? S_IDLE : S_MAC;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // NOTE: weights are flops rather than RAM because reset must clear every entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_W; k++) w_mem[k] <= '0;
        end else if (w_wr_ok) begin
            w_mem[w_addr] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_cnt        <= '0;
            j_cnt        <= '0;
            acc          <= '0;
            relu_q       <= 1'b0;
            valid        <= 1'b0;
            output_block <= '0;
            for (int k = 0; k < N_IN; k++)  x_q[k]     <= '0;
            for (int k = 0; k < N_OUT; k++) res_mem[k] <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                S_IDLE: if (init) begin
                    for (int k = 0; k < N_IN; k++) x_q[k] <= input_block[k*DATA_W +: DATA_W];
                    relu_q <= relu_en;
                    acc    <= '0;
                    i_cnt  <= '0;
                    j_cnt  <= '0;
                end
                S_MAC: begin
                    acc   <= acc + ACC_W'(prod);
                    i_cnt <= i_last ? '0 : i_cnt + 1'b1;
                end
                S_STORE: begin
                    res_mem[j_cnt] <= res_sat;
                    acc            <= '0;
                    i_cnt          <= '0;
                    if (j_last) begin
                        // The final slot is still in flight, so it is merged directly into the output.
                        for (int k = 0; k < N_OUT; k++)
                            output_block[k*DATA_W +: DATA_W] <= (JW'(k) == j_cnt) ? res_sat : res_mem[k];
                        valid <= 1'b1;
                    end else begin
                        j_cnt <= j_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mlp_dense_engine.md
Name: mlp_dense_engine

Overview:
- Parametrised, sequential MLP dense layer for the transformer datapath.
- Computes out[j] = act((sum_i x[i]*W[j][i]) >>> SHIFT) for N_OUT neurons over N_IN signed inputs, using one time-multiplexed MAC.
- Generalises the single-width init/ready MLP block with vector width, layer size, a run-time weight load port, requantisation, saturation and a selectable ReLU mode.

Parameters:
DATA_W, 8, signed element width for inputs, weights and outputs
N_IN, 4, input vector length (>=1)
N_OUT, 4, output vector length / neurons (>=1)
SHIFT, 0, arithmetic right shift applied to each accumulator before activation
ACC_W, 2*DATA_W+$clog2(N_IN)+1, accumulator width (derived; not overridden)
WA_W, $clog2(N_IN*N_OUT) (min 1), weight address width (derived)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
init  in  1  start request; accepted only when ready=1
ready  out  1  1 = idle, can accept init or weight writes
valid  out  1  one-cycle pulse, output_block holds a fresh result
relu_en  in  1  1 = ReLU activation, 0 = identity; sampled with init
input_block  in  N_IN*DATA_W  element i at bits [i*DATA_W +: DATA_W], signed; sampled with init
output_block  out  N_OUT*DATA_W  element j at bits [j*DATA_W +: DATA_W], signed
w_we  in  1  weight write enable
w_addr  in  WA_W  weight index = j*N_IN + i
w_data  in  DATA_W  signed weight value

Behaviour:
- Clock and reset: single clock clk. reset_n is asynchronous, active-low.
- Reset values: ready=1, valid=0, output_block=0, all weights=0, FSM=IDLE, counters=0, accumulator=0.
- FSM states and transitions:
  - IDLE: ready=1. init=1 latches input_block and relu_en, clears acc, i=0, j=0, goes to MAC; ready=0 from next cycle.
  - MAC: acc += x[i]*W[j][i] each cycle (full-precision signed product). i increments; after i=N_IN-1 goes to STORE.
  - STORE: res = acc >>> SHIFT (floor toward -inf). If relu_en and res<0, res=0. Saturate res to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Write res into internal result slot j, clear acc, i=0.
    - j<N_OUT-1: j++, back to MAC.
    - j=N_OUT-1: go to IDLE, copy all result slots to output_block, assert valid, ready=1, all on the same edge.
- Latency: valid and ready rise exactly N_OUT*(N_IN+1) rising edges after the edge that sampled init (20 for 4x4). valid stays high for exactly one cycle.
- Throughput: a new init may be accepted in the same cycle valid is high, because ready=1 then.
- output_block holds its last value while busy and changes only on the valid edge.
- Weight writes: applied on the rising edge when w_we=1, ready=1, init=0 and w_addr<N_IN*N_OUT. Otherwise the write is silently dropped:
  - write while busy
  - write in the same cycle as an accepted init
  - out-of-range address
- Weights persist across runs; only reset clears them.
- init while busy: ignored; no queueing.
- input_block and relu_en changes while busy: no effect on the current run.
- Reset mid-run: immediately forces the reset values, abandoning the computation. No valid is produced for the aborted run.
- Accumulator sizing: ACC_W never overflows for any input/weight combination. Saturation applies only at the output.

Test Plan:
- Identity: W[j][j]=1, others 0; input [1,2,3,4]; relu_en=0 -> output [1,2,3,4]. valid pulse exactly 20 edges after init, ready=0 for edges 1..19.
- Saturation: all weights=127, inputs all 127 (acc=64516) -> all outputs 127. All weights=-128, inputs all 127 -> all outputs -128.
- ReLU mode: W = -1 * identity, input [5,6,7,8].
  - relu_en=1 -> [0,0,0,0]
  - relu_en=0 -> [-5,-6,-7,-8]
- Requantisation with SHIFT=2: single weight 1, inputs 7 and -7 -> outputs 1 and -2 (floor).
- Protocol robustness:
  - a weight write during busy is ignored (next run uses the old weight);
  - an out-of-range w_addr is ignored;
  - a second init mid-run is ignored, still giving one valid at edge 20;
  - back-to-back init in the valid cycle starts the next run.
- Reset mid-run: assert reset_n=0 at edge 10 -> ready=1, valid=0, output_block=0, weights cleared. No valid follows. A new run after release with zero weights gives all-zero outputs.
